shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 28 ++
 rtl/shift_sequencer.sv | 98 +++++++++
 tb/tb_shift_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Shift sequencer bus: request fields from the pipeline and status/result back.
//   master: pipeline side (drives start/op/amounts/data/flush)
//   slave : sequencer side (drives busy/done/result)
// Handshake: a request is taken at a rising edge where start=1, flush=0 and the
// sequencer is not busy; done is a one-cycle pulse qualifying result, and busy
// stays high while a request is being worked on (start is ignored then).
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt_imm;
  logic [4:0]  shamt_reg;
  logic        use_reg;
  logic [31:0] data_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, shamt_imm, shamt_reg, use_reg, data_in, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt_imm, shamt_reg, use_reg, data_in, flush,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: one bit per clock for SLL, SRL, SRA and ROTR.
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - shift_sequencer_if.slave (request fields, busy/done/result)
//   dbg_state - current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module shift_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_sequencer_if.slave      bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [1:0]  op_q;
  logic [4:0]  cnt;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  amt_sel;
  logic [31:0] work_next;

  assign amt_sel = bus.use_reg ? bus.shamt_reg : bus.shamt_imm;

  // One-bit step of the latched operation.
  always_comb begin
    work_next = work;
    case (op_q)
      2'b00:   work_next = {work[30:0], 1'b0};
      2'b01:   work_next = {1'b0, work[31:1]};
      2'b10:   work_next = {work[31], work[31:1]};
      default: work_next = {work[0], work[31:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= 32'h0;
      op_q     <= 2'b00;
      cnt      <= 5'd0;
      result_q <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a start on the same edge.
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work   <= bus.data_in;
            op_q   <= bus.op;
            cnt    <= amt_sel;
            state  <= SHIFT;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            work <= work_next;
            cnt  <= cnt - 5'd1;
          end else begin
            result_q <= work;
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: driver tasks push expected results into
// exp_q; a monitor pops and compares on every done pulse.
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  shift_sequencer_if sif ();

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sif.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] last_result = 32'h0;
  logic        prev_done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge rst_n) begin
    last_result = 32'h0;
    prev_done   = 1'b0;
  end

  // Monitor: result compare on done, result stability otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("result", sif.result, exp_q.pop_front());
        end
        check("done_one_cycle", {31'h0, prev_done}, 32'h0);
        check("done_not_busy", {31'h0, sif.busy}, 32'h0);
      end else begin
        check("result_hold", sif.result, last_result);
      end
      last_result = sif.result;
      prev_done   = sif.done;
    end
  end

  // ---------------- driver tasks ----------------
  // Counts negedges after the accepting edge until done; checks latency and busy.
  task automatic wait_done(input int amt, input string tag);
    int busy_n;
    int done_cyc;
    busy_n   = 0;
    done_cyc = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (sif.done) begin
        done_cyc = k;
        break;
      end
      if (sif.busy) busy_n++;
    end
    check({tag, "_done_cycle"}, done_cyc, amt + 2);
    check({tag, "_busy_cycles"}, busy_n, amt + 1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic ur, input logic [4:0] imm,
                        input logic [4:0] rg, input logic [31:0] d,
                        input logic [31:0] exp, input int amt, input string tag);
    @(negedge clk);
    sif.start = 1'b1; sif.op = o; sif.use_reg = ur;
    sif.shamt_imm = imm; sif.shamt_reg = rg; sif.data_in = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    // Scramble fields after acceptance; the operation must not notice.
    sif.start = 1'b0; sif.op = ~o; sif.use_reg = ~ur;
    sif.shamt_imm = imm ^ 5'h15; sif.shamt_reg = rg ^ 5'h0a; sif.data_in = ~d;
    wait_done(amt, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_seen;
    rst_n = 1'b0;
    sif.start = 1'b0; sif.op = 2'b00; sif.shamt_imm = 5'd0; sif.shamt_reg = 5'd0;
    sif.use_reg = 1'b0; sif.data_in = 32'h0; sif.flush = 1'b0;

    #7;
    check("rst_busy",   {31'h0, sif.busy}, 32'h0);
    check("rst_done",   {31'h0, sif.done}, 32'h0);
    check("rst_result", sif.result, 32'h0);
    check("rst_state",  {30'h0, dbg_state}, 32'h0);
    #6 rst_n = 1'b1;

    // SRA by immediate 4
    run_op(2'b10, 1'b0, 5'd4, 5'd9, 32'h80000010, 32'hF8000001, 4, "sra4");
    // SLL by 0
    run_op(2'b00, 1'b0, 5'd0, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 0, "sll0");
    // SRL / ROTR by register 31
    run_op(2'b01, 1'b1, 5'd3, 5'd31, 32'h80000001, 32'h00000001, 31, "srl31");
    run_op(2'b11, 1'b1, 5'd3, 5'd31, 32'h80000001, 32'h00000003, 31, "rotr31");
    // ROTR by immediate 4
    run_op(2'b11, 1'b0, 5'd4, 5'd0, 32'h12345678, 32'h81234567, 4, "rotr4");

    // Back-to-back: start held high through SHIFT and DONE.
    @(negedge clk);
    sif.start = 1'b1; sif.op = 2'b00; sif.use_reg = 1'b0;
    sif.shamt_imm = 5'd1; sif.data_in = 32'h1;
    exp_q.push_back(32'h2);
    @(posedge clk);
    #1 sif.shamt_imm = 5'd2;   // must not affect the first operation
    wait_done(1, "b2b_first");
    exp_q.push_back(32'h4);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    check("b2b_no_idle_busy",  {31'h0, sif.busy}, 32'h1);
    check("b2b_no_idle_state", {30'h0, dbg_state}, 32'h1);
    wait_done(2, "b2b_second");

    // Flush at the 3rd SHIFT cycle of a 10-bit shift, with a colliding start.
    @(negedge clk);
    sif.start = 1'b1; sif.op = 2'b00; sif.use_reg = 1'b0;
    sif.shamt_imm = 5'd10; sif.data_in = 32'h12345678;
    @(posedge clk);
    #1 sif.start = 1'b0;
    repeat (3) @(negedge clk);
    sif.flush = 1'b1; sif.start = 1'b1; sif.shamt_imm = 5'd1;
    @(posedge clk);
    #1;
    sif.flush = 1'b0; sif.start = 1'b0;
    check("flush_state",  {30'h0, dbg_state}, 32'h0);
    check("flush_busy",   {31'h0, sif.busy}, 32'h0);
    check("flush_result", sif.result, 32'h4);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (sif.done) done_seen++;
    end
    check("flush_no_done", done_seen, 0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    sif.start = 1'b1; sif.op = 2'b01; sif.shamt_imm = 5'd10; sif.data_in = 32'hFFFF0000;
    @(posedge clk);
    #1 sif.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'h0, sif.busy}, 32'h0);
    check("arst_result", sif.result, 32'h0);
    check("arst_done",   {31'h0, sif.done}, 32'h0);
    check("arst_state",  {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (sif.done) done_seen++;
    end
    check("arst_no_done", done_seen, 0);

    // First start after reset is accepted immediately; SRA by register 3.
    run_op(2'b10, 1'b1, 5'd7, 5'd3, 32'h000000F0, 32'h0000001E, 3, "post_rst");

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
